cnn_inst_poll_master: RTL and testbench
=======================================

Name: cnn_inst_poll_master

Overview:
- Avalon-MM read master on the FPGA side that polls a fixed-latency, read-only status/instruction slave: a 32-bit input port with a 2-bit address, readdata registered one cycle after the read.
- Issues periodic single-word reads to POLL_ADDR and captures readdata after READ_LATENCY cycles.
- Delivers each captured word to downstream CNN control logic over a valid/ready handshake.
- Backpressure from downstream pauses polling.

Parameters:
- ADDR_W, 2, Avalon address width.
- DATA_W, 32, readdata / inst_data width.
- READ_LATENCY, 1, slave read latency in cycles; legal range 1..15.
- POLL_INTERVAL, 16, idle cycles between the end of one transaction and the next read request; legal range 1..65535.
- POLL_ADDR, 0, word address polled.

Ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  polling enable.
- avm_address  out  ADDR_W  Avalon address; equals POLL_ADDR while avm_read=1, else 0.
- avm_read  out  1  Avalon read request.
- avm_waitrequest  in  1  slave stall; tie 0 for fixed-latency slaves.
- avm_readdata  in  DATA_W  slave read data.
- inst_data  out  DATA_W  last delivered word.
- inst_valid  out  1  inst_data valid; held until accepted.
- inst_ready  in  1  downstream accept.
- poll_count  out  16  completed-read counter.

Behaviour:
- Reset (synchronous, active-high, overrides everything including mid-transaction):
  - state=IDLE.
  - avm_read=0, avm_address=0.
  - inst_data=0, inst_valid=0, poll_count=0.
  - latency and gap counters=0.
  - first_flag=1.
- States: IDLE, REQ, WAIT, HOLD, GAP. Outputs are decoded from registered state: avm_read=(state==REQ), inst_valid=(state==HOLD).
- IDLE: go to REQ on the edge where enable=1.
- REQ:
  - avm_read=1, avm_address=POLL_ADDR.
  - Remain while avm_waitrequest=1. enable is ignored here; the Avalon request is never withdrawn.
  - On a cycle with avm_waitrequest=0, the read is accepted: load latency counter with READ_LATENCY, go to WAIT.
- WAIT:
  - Lasts exactly READ_LATENCY cycles.
  - On the last WAIT cycle, sample avm_readdata and increment poll_count (wraps 0xFFFF->0x0000).
  - Emit decision made on that sample (see Optional Feature): emit -> inst_data<=sample, go to HOLD; no emit -> go to GAP.
- HOLD:
  - inst_valid=1; inst_data stable.
  - On inst_valid & inst_ready, go to GAP.
  - No new read is issued while in HOLD.
- GAP:
  - Count POLL_INTERVAL cycles.
  - On the last count: go to REQ if enable=1, else IDLE.
  - Deasserting enable in WAIT/HOLD/GAP completes the current transaction and delivery, then parks in IDLE.
- Latency:
  - enable sampled at edge 0 -> avm_read high cycle 1.
  - With waitrequest=0 and READ_LATENCY=1: WAIT in cycle 2, inst_valid high in cycle 3.
- Poll period: 1 + READ_LATENCY + POLL_INTERVAL cycles, plus HOLD cycles (>=1) when emitting.
- No outstanding reads beyond one; only one transaction in flight at any time.

Optional Feature:
- Macro CNN_INST_CHANGE_DET_EN.
- Defined:
  - Keep last_sample register (reset 0).
  - Emit only if first_flag=1 or sample != last_sample.
  - last_sample updated on every sample; first_flag cleared on the first sample.
  - Unchanged samples go WAIT->GAP with no inst_valid pulse; poll_count still increments.
- Not defined: every sample is emitted; last_sample and first_flag are not synthesized.

Test Plan:
- Reset then enable=1 at edge 0, waitrequest=0, READ_LATENCY=1, slave returns 0x0000_00A5, inst_ready=1 -> avm_read=1 in cycle 1 only, avm_address=0, inst_valid=1 in cycle 3 with inst_data=0x0000_00A5, poll_count=1.
- Continuous polling with inst_ready=1, POLL_INTERVAL=16, macro undefined -> avm_read pulses every 19 cycles; poll_count=5 after 5 reads.
- avm_waitrequest held high 4 cycles in REQ -> avm_read and avm_address stay asserted for 5 cycles; data sampled READ_LATENCY cycles after the accepting cycle.
- inst_ready=0 for 10 cycles during HOLD -> inst_valid and inst_data stable, no avm_read; polling resumes POLL_INTERVAL cycles after the handshake.
- CNN_INST_CHANGE_DET_EN defined, slave returns 0x11, 0x11, 0x22 -> exactly two inst_valid handshakes (0x11, 0x22), poll_count=3.
- Reset asserted during WAIT, and separately enable=0 during GAP:
  - Reset in WAIT -> next cycle all outputs at reset values, state IDLE.
  - enable=0 in GAP -> gap completes, no further avm_read.

Source files
------------

// File: rtl/cnn_inst_poll_master.sv
// -----------------------------------------------------------------------------
// cnn_inst_poll_master
//
// Avalon-MM read master that periodically polls one word of a fixed-latency,
// read-only status/instruction slave. Each captured word is handed to the
// downstream CNN control logic over a valid/ready handshake. While a word
// waits for acceptance, no new read is issued, so backpressure pauses polling.
// Only one read transaction is ever in flight.
//
// Optional feature (compile-time macro CNN_INST_CHANGE_DET_EN):
//   When defined, a word is delivered only if it is the first sample since
//   reset or differs from the previous sample. Unchanged samples still count
//   in poll_count but produce no inst_valid pulse.
//   When undefined, every sample is delivered.
//
// Ports:
//   clk              in   single clock
//   reset            in   synchronous, active-high reset
//   enable           in   polling enable
//   avm_address      out  Avalon address (POLL_ADDR while avm_read, else 0)
//   avm_read         out  Avalon read request
//   avm_waitrequest  in   slave stall
//   avm_readdata     in   slave read data
//   inst_data        out  last delivered word
//   inst_valid       out  inst_data valid, held until accepted
//   inst_ready       in   downstream accept
//   poll_count       out  completed-read counter (wraps)
// -----------------------------------------------------------------------------
module cnn_inst_poll_master #(
   parameter int ADDR_W        = 2,
   parameter int DATA_W        = 32,
   parameter int READ_LATENCY  = 1,
   parameter int POLL_INTERVAL = 16,
   parameter int POLL_ADDR     = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   output logic [ADDR_W-1:0] avm_address,
   output logic              avm_read,
   input  logic              avm_waitrequest,
   input  logic [DATA_W-1:0] avm_readdata,
   output logic [DATA_W-1:0] inst_data,
   output logic              inst_valid,
   input  logic              inst_ready,
   output logic [15:0]       poll_count
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_REQ  = 3'd1,
      S_WAIT = 3'd2,
      S_HOLD = 3'd3,
      S_GAP  = 3'd4
   } state_t;

   state_t            state_q,      state_d;
   logic [3:0]        lat_cnt_q,    lat_cnt_d;
   logic [15:0]       gap_cnt_q,    gap_cnt_d;
   logic [DATA_W-1:0] inst_data_q,  inst_data_d;
   logic [15:0]       poll_count_q, poll_count_d;
   logic              emit;

`ifdef CNN_INST_CHANGE_DET_EN
   logic              first_flag_q,  first_flag_d;
   logic [DATA_W-1:0] last_sample_q, last_sample_d;
`endif

   // Outputs decode straight from registered state, so they are glitch-free.
   assign avm_read    = (state_q == S_REQ);
   assign avm_address = (state_q == S_REQ) ? ADDR_W'(POLL_ADDR) : '0;
   assign inst_valid  = (state_q == S_HOLD);
   assign inst_data   = inst_data_q;
   assign poll_count  = poll_count_q;

   always_comb begin
      state_d      = state_q;
      lat_cnt_d    = lat_cnt_q;
      gap_cnt_d    = gap_cnt_q;
      inst_data_d  = inst_data_q;
      poll_count_d = poll_count_q;
`ifdef CNN_INST_CHANGE_DET_EN
      first_flag_d  = first_flag_q;
      last_sample_d = last_sample_q;
      // Deliver the first sample after reset, then only changed samples.
      emit          = first_flag_q || (avm_readdata != last_sample_q);
`else
      emit          = 1'b1;
`endif

      case (state_q)
         S_IDLE: begin
            if (enable) begin
               state_d = S_REQ;
            end
         end
         S_REQ: begin
            // The request is held until the slave accepts it; enable is not
            // consulted so the Avalon read is never withdrawn.
            if (!avm_waitrequest) begin
               lat_cnt_d = 4'(READ_LATENCY);
               state_d   = S_WAIT;
            end
         end
         S_WAIT: begin
            lat_cnt_d = lat_cnt_q - 4'd1;
            if (lat_cnt_q == 4'd1) begin
               poll_count_d = poll_count_q + 16'd1;
`ifdef CNN_INST_CHANGE_DET_EN
               first_flag_d  = 1'b0;
               last_sample_d = avm_readdata;
`endif
               if (emit) begin
                  inst_data_d = avm_readdata;
                  state_d     = S_HOLD;
               end else begin
                  gap_cnt_d = 16'(POLL_INTERVAL);
                  state_d   = S_GAP;
               end
            end
         end
         S_HOLD: begin
            if (inst_ready) begin
               gap_cnt_d = 16'(POLL_INTERVAL);
               state_d   = S_GAP;
            end
         end
         S_GAP: begin
            gap_cnt_d = gap_cnt_q - 16'd1;
            // enable is only consulted here, so a transaction started while
            // enabled always runs to completion before parking.
            if (gap_cnt_q == 16'd1) begin
               state_d = enable ? S_REQ : S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         lat_cnt_q    <= '0;
         gap_cnt_q    <= '0;
         inst_data_q  <= '0;
         poll_count_q <= '0;
`ifdef CNN_INST_CHANGE_DET_EN
         first_flag_q  <= 1'b1;
         last_sample_q <= '0;
`endif
      end else begin
         state_q      <= state_d;
         lat_cnt_q    <= lat_cnt_d;
         gap_cnt_q    <= gap_cnt_d;
         inst_data_q  <= inst_data_d;
         poll_count_q <= poll_count_d;
`ifdef CNN_INST_CHANGE_DET_EN
         first_flag_q  <= first_flag_d;
         last_sample_q <= last_sample_d;
`endif
      end
   end

endmodule

// File: tb/tb_cnn_inst_poll_master.sv
// -----------------------------------------------------------------------------
// Testbench for cnn_inst_poll_master (default parameters).
// A fixed-latency slave and a transaction-level reference model live in a
// negedge monitor; directed sequences and a randomized phase drive the DUT.
// -----------------------------------------------------------------------------
module tb_cnn_inst_poll_master;

   localparam int          RL    = 1;
   localparam int          PI    = 16;
   localparam logic [1:0]  PADDR = 2'd0;
`ifdef CNN_INST_CHANGE_DET_EN
   localparam bit          CHG   = 1'b1;
`else
   localparam bit          CHG   = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic [1:0]  avm_address;
   logic        avm_read;
   logic        avm_waitrequest;
   logic [31:0] avm_readdata;
   logic [31:0] inst_data;
   logic        inst_valid;
   logic        inst_ready;
   logic [15:0] poll_count;

   always #5 clk = ~clk;

   cnn_inst_poll_master #(
      .ADDR_W(2), .DATA_W(32), .READ_LATENCY(RL),
      .POLL_INTERVAL(PI), .POLL_ADDR(0)
   ) dut (
      .clk(clk), .reset(reset), .enable(enable),
      .avm_address(avm_address), .avm_read(avm_read),
      .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
      .inst_data(inst_data), .inst_valid(inst_valid),
      .inst_ready(inst_ready), .poll_count(poll_count)
   );

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
   endtask

   // ---------------- reference model (transaction level) ----------------
   logic [31:0] exp_q[$];
   logic [15:0] m_count;
   logic        m_first;
   logic [31:0] m_last;
   int          n_acc   = 0;
   int          n_deliv = 0;

   task automatic model_reset();
      exp_q.delete();
      m_count = 16'd0;
      m_first = 1'b1;
      m_last  = 32'd0;
   endtask

   task automatic model_accept(input logic [31:0] w);
      bit e;
      m_count = m_count + 16'd1;
      e = !CHG || m_first || (w != m_last);
      m_first = 1'b0;
      m_last  = w;
      if (e) exp_q.push_back(w);
   endtask

   // ---------------- slave + monitor ----------------
   logic [31:0] slave_words[$];
   logic [31:0] pend, s_last, w, tmp;
   logic        pend_v = 1'b0;
   logic        mon_en = 1'b0;
   logic        per_chk = 1'b0;
   logic        prev_v = 1'b0, prev_r = 1'b0, prev_rd = 1'b0, have_prev = 1'b0;
   logic [31:0] prev_d = '0;
   int          cyc_since = 0, req_cyc = 0, val_cyc = 0;

   initial s_last = 32'd0;

   always @(negedge clk) begin
      // Readdata is valid for exactly one cycle, READ_LATENCY (=1) after accept.
      if (pend_v) begin
         avm_readdata = pend;
         pend_v = 1'b0;
      end else begin
         avm_readdata = $urandom;
      end
      if (!reset && avm_read && !avm_waitrequest) begin
         if (slave_words.size() != 0) w = slave_words.pop_front();
         else if ($urandom_range(0, 3) == 0) w = s_last;
         else w = $urandom;
         s_last = w;
         pend   = w;
         pend_v = 1'b1;
         n_acc++;
         model_accept(w);
      end
      if (mon_en && !reset) begin
         chk("avm_address", avm_address, avm_read ? PADDR : 2'd0);
         chk("read_while_valid", avm_read & inst_valid, 1'b0);
         if (prev_v && !prev_r) begin
            chk("hold_valid", inst_valid, 1'b1);
            chk("hold_data", inst_data, prev_d);
         end
         if (inst_valid && inst_ready) begin
            n_deliv++;
            if (exp_q.size() == 0) begin
               n_chk++;
               $display("FAIL delivery: got unexpected word 0x%0h, expected none", inst_data);
            end else begin
               tmp = exp_q.pop_front();
               chk("inst_data", inst_data, tmp);
            end
         end
         // Request-to-request period: REQ cycles + latency + HOLD cycles + gap.
         if (!per_chk) have_prev = 1'b0;
         if (avm_read && !prev_rd) begin
            if (per_chk && have_prev)
               chk("poll_period", cyc_since, req_cyc + RL + val_cyc + PI);
            have_prev = per_chk;
            cyc_since = 0; req_cyc = 0; val_cyc = 0;
         end
         cyc_since++;
         if (avm_read)   req_cyc++;
         if (inst_valid) val_cyc++;
         prev_v  = inst_valid;
         prev_r  = inst_ready;
         prev_d  = inst_data;
         prev_rd = avm_read;
      end
   end

   // ---------------- helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      model_reset();
      tick();
      reset = 1'b0;
   endtask

   task automatic wait_read(input int budget);
      for (int i = 0; i < budget && !avm_read; i++) tick();
      chk("wait_read_timeout", avm_read, 1'b1);
   endtask

   task automatic wait_valid(input int budget);
      for (int i = 0; i < budget && !inst_valid; i++) tick();
      chk("wait_valid_timeout", inst_valid, 1'b1);
   endtask

   task automatic wait_deliv(input int target, input int budget);
      for (int i = 0; i < budget && n_deliv < target; i++) tick();
      chk("wait_deliv_timeout", (n_deliv >= target), 1'b1);
   endtask

   task automatic idle_check(input int cycles);
      int reads = 0;
      for (int i = 0; i < cycles; i++) begin
         tick();
         if (avm_read) reads++;
      end
      chk("reads_after_disable", reads, 0);
   endtask

   typedef struct {
      logic        en;
      logic        rdy;
      logic        exp_read;
      logic        exp_valid;
      logic [31:0] exp_data;
      logic [15:0] exp_cnt;
   } vec_t;

   vec_t tbl[5];
   int   base, base_a, reads;
   logic [31:0] d0;

   initial begin
      tbl[0] = '{en: 1'b1, rdy: 1'b1, exp_read: 1'b1, exp_valid: 1'b0, exp_data: 32'h0,  exp_cnt: 16'd0};
      tbl[1] = '{en: 1'b1, rdy: 1'b1, exp_read: 1'b0, exp_valid: 1'b0, exp_data: 32'h0,  exp_cnt: 16'd0};
      tbl[2] = '{en: 1'b1, rdy: 1'b1, exp_read: 1'b0, exp_valid: 1'b1, exp_data: 32'hA5, exp_cnt: 16'd1};
      tbl[3] = '{en: 1'b0, rdy: 1'b1, exp_read: 1'b0, exp_valid: 1'b0, exp_data: 32'hA5, exp_cnt: 16'd1};
      tbl[4] = '{en: 1'b0, rdy: 1'b1, exp_read: 1'b0, exp_valid: 1'b0, exp_data: 32'hA5, exp_cnt: 16'd1};

      reset = 1'b1; enable = 1'b0; avm_waitrequest = 1'b0; inst_ready = 1'b1;
      model_reset();
      repeat (3) tick();
      chk("rst_read", avm_read, 1'b0);
      chk("rst_addr", avm_address, 2'd0);
      chk("rst_valid", inst_valid, 1'b0);
      chk("rst_data", inst_data, 32'd0);
      chk("rst_count", poll_count, 16'd0);
      reset  = 1'b0;
      mon_en = 1'b1;

      // First transaction, cycle by cycle; enable drops during GAP.
      slave_words.push_back(32'h0000_00A5);
      for (int i = 0; i < 5; i++) begin
         enable     = tbl[i].en;
         inst_ready = tbl[i].rdy;
         tick();
         chk($sformatf("tbl%0d_read", i),  avm_read,   tbl[i].exp_read);
         chk($sformatf("tbl%0d_valid", i), inst_valid, tbl[i].exp_valid);
         chk($sformatf("tbl%0d_data", i),  inst_data,  tbl[i].exp_data);
         chk($sformatf("tbl%0d_count", i), poll_count, tbl[i].exp_cnt);
      end
      idle_check(40);
      chk("gap_park_count", poll_count, 16'd1);

      // Continuous polling, five reads.
      do_reset();
      per_chk = 1'b1;
      enable  = 1'b1;
      base    = n_deliv;
      wait_deliv(base + 5, 300);
      enable  = 1'b0;
      per_chk = 1'b0;
      idle_check(40);
      chk("cont_count", poll_count, 16'd5);
      chk("cont_model_count", poll_count, m_count);

      // Backpressure: ready low for 10 cycles during HOLD.
      per_chk    = 1'b1;
      inst_ready = 1'b0;
      enable     = 1'b1;
      base       = n_deliv;
      wait_valid(60);
      d0 = inst_data;
      for (int i = 0; i < 10; i++) begin
         chk("bp_valid", inst_valid, 1'b1);
         chk("bp_data", inst_data, d0);
         chk("bp_noread", avm_read, 1'b0);
         tick();
      end
      inst_ready = 1'b1;
      wait_deliv(base + 2, 100);
      enable  = 1'b0;
      per_chk = 1'b0;
      idle_check(40);

      // Waitrequest held high for 4 cycles in REQ.
      avm_waitrequest = 1'b1;
      enable = 1'b1;
      base   = n_deliv;
      wait_read(60);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("wr_read_held", avm_read, 1'b1);
         chk("wr_addr_held", avm_address, PADDR);
      end
      avm_waitrequest = 1'b0;
      enable = 1'b0;
      tick();
      chk("wr_read_drop", avm_read, 1'b0);
      wait_deliv(base + 1, 50);
      idle_check(40);

      // Change detection sequence 0x11, 0x11, 0x22.
      do_reset();
      slave_words.push_back(32'h11);
      slave_words.push_back(32'h11);
      slave_words.push_back(32'h22);
      base   = n_deliv;
      base_a = n_acc;
      enable = 1'b1;
      for (int i = 0; i < 200 && n_acc < base_a + 3; i++) tick();
      chk("chg_accepts", n_acc - base_a, 3);
      enable = 1'b0;
      idle_check(40);
      chk("chg_deliveries", n_deliv - base, CHG ? 2 : 3);
      chk("chg_count", poll_count, 16'd3);

      // Randomized backpressure and data.
      per_chk = 1'b1;
      enable  = 1'b1;
      for (int i = 0; i < 400; i++) begin
         inst_ready = 1'($urandom_range(0, 1));
         tick();
      end
      inst_ready = 1'b1;
      enable  = 1'b0;
      per_chk = 1'b0;
      idle_check(60);
      chk("rand_count", poll_count, m_count);
      chk("rand_pending", exp_q.size(), 0);

      // Reset during WAIT.
      enable = 1'b1;
      wait_read(60);
      tick();
      chk("rw_in_wait", avm_read | inst_valid, 1'b0);
      reset = 1'b1;
      model_reset();
      tick();
      chk("rw_read", avm_read, 1'b0);
      chk("rw_addr", avm_address, 2'd0);
      chk("rw_valid", inst_valid, 1'b0);
      chk("rw_data", inst_data, 32'd0);
      chk("rw_count", poll_count, 16'd0);
      enable = 1'b0;
      reset  = 1'b0;
      reads  = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (avm_read || inst_valid) reads++;
      end
      chk("rw_stays_idle", reads, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
